// File: rtl/dispatch_pkg.sv
// Shared definitions for the instruction dispatcher.
//   state_t       : dispatcher FSM encoding (also exported on the debug port)
//   DEFAULT_DEPTH : default queue depth (entries, power of two)
//   DEFAULT_TMO   : default watchdog limit in WAIT cycles
//   INST_W        : instruction word width
//   RETIRED_W     : width of the retired-instruction counter
package dispatch_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ISSUE  = 3'd1,
    S_WAIT   = 3'd2,
    S_RETIRE = 3'd3,
    S_ERR    = 3'd4
  } state_t;

  localparam int DEFAULT_DEPTH = 4;
  localparam int DEFAULT_TMO   = 15;
  localparam int INST_W        = 16;
  localparam int RETIRED_W     = 8;

endpackage

// File: rtl/inst_fifo.sv
// Instruction queue: DEPTH-entry FIFO with wrap-around pointers.
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   push, push_data   : write push_data at the tail on this edge
//   pop               : drop the head entry on this edge (never on empty)
//   head              : current head entry (combinational read)
//   full, empty       : status
//   count             : occupancy, one bit wider than the pointers
// Push and pop in the same cycle are both honoured, leaving count unchanged,
// which also holds when the queue is full.
module inst_fifo
  import dispatch_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int WIDTH = INST_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;

  // Storage needs no reset: an entry is only read after it was written.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == (PW+1)'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/inst_dispatch.sv
// Instruction dispatcher: two requesters feed a shared queue through a
// round-robin arbiter; an FSM issues queued words one at a time to the
// datapath and retires them on cpu_done, with a watchdog on the wait.
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   req_a/req_b           : requester holds a valid word (valid)
//   inst_a/inst_b         : the offered word, stable while req is high
//   gnt_a/gnt_b           : combinational accept (ready)
//   cpu_run, cpu_inst     : registered run strobe and instruction
//   cpu_done              : datapath completion pulse, honoured in WAIT only
//   q_full, q_empty       : queue status
//   busy                  : FSM not in IDLE
//   retired               : completed-instruction count, wraps at 255
//   timeout_err           : sticky watchdog flag (FSM parked in ERR)
//   fsm_state             : current FSM state, for debug/checkers
// Handshake: req_x acts as valid and gnt_x as ready; a word transfers into
// the queue on a rising clock edge where both are high. gnt_x is only ever
// high together with req_x, and at most one grant is high per cycle.
module inst_dispatch
  import dispatch_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int TMO   = DEFAULT_TMO
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_a,
  input  logic                 req_b,
  input  logic [INST_W-1:0]    inst_a,
  input  logic [INST_W-1:0]    inst_b,
  output logic                 gnt_a,
  output logic                 gnt_b,
  output logic                 cpu_run,
  output logic [INST_W-1:0]    cpu_inst,
  input  logic                 cpu_done,
  output logic                 q_full,
  output logic                 q_empty,
  output logic                 busy,
  output logic [RETIRED_W-1:0] retired,
  output logic                 timeout_err,
  output state_t               fsm_state
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int WW = $clog2(TMO + 1);

  state_t              state;
  state_t              state_next;
  logic [WW-1:0]       wd_cnt;
  logic                prio_a;
  logic                push;
  logic                pop;
  logic                can_accept;
  logic [INST_W-1:0]   push_data;
  logic [INST_W-1:0]   head;
  logic [CW-1:0]       count;

  // ---------------------------------------------------------------------
  // Arbitration. A pop in RETIRE frees a slot in the same cycle, so a full
  // queue can still accept then. prio_a says who wins a tie.
  // ---------------------------------------------------------------------
  assign pop = (state == S_RETIRE);

  always_comb begin
    gnt_a      = 1'b0;
    gnt_b      = 1'b0;
    can_accept = !q_full || pop;
    if (!reset && can_accept) begin
      if (req_a && req_b) begin
        gnt_a = prio_a;
        gnt_b = !prio_a;
      end else begin
        gnt_a = req_a;
        gnt_b = req_b;
      end
    end
  end

  assign push      = gnt_a | gnt_b;
  assign push_data = gnt_b ? inst_b : inst_a;

  always_ff @(posedge clk) begin
    if (reset) begin
      prio_a <= 1'b1;
    end else if (gnt_a) begin
      prio_a <= 1'b0;
    end else if (gnt_b) begin
      prio_a <= 1'b1;
    end
  end

  inst_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (INST_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .full      (q_full),
    .empty     (q_empty),
    .count     (count)
  );

  // ---------------------------------------------------------------------
  // Dispatch FSM
  // ---------------------------------------------------------------------
  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE: begin
        if (!q_empty) state_next = S_ISSUE;
      end
      S_ISSUE: begin
        state_next = S_WAIT;
      end
      S_WAIT: begin
        // Completion wins over a timeout landing in the same cycle.
        if (cpu_done) begin
          state_next = S_RETIRE;
        end else if (wd_cnt == WW'(TMO - 1)) begin
          state_next = S_ERR;
        end
      end
      S_RETIRE: begin
        // Words left after this pop: count - 1 plus a same-cycle push.
        if (count > CW'(1) || push) begin
          state_next = S_ISSUE;
        end else begin
          state_next = S_IDLE;
        end
      end
      S_ERR: begin
        state_next = S_ERR;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      wd_cnt   <= '0;
      retired  <= '0;
      cpu_run  <= 1'b0;
      cpu_inst <= '0;
    end else begin
      state <= state_next;
      // cpu_run is high for exactly the cycles spent in WAIT.
      cpu_run <= (state_next == S_WAIT);
      if (state == S_ISSUE) begin
        cpu_inst <= head;
        wd_cnt   <= '0;
      end else if (state == S_WAIT) begin
        wd_cnt <= wd_cnt + 1'b1;
      end
      if (state == S_RETIRE) begin
        retired <= retired + 1'b1;
      end
    end
  end

  assign busy        = (state != S_IDLE);
  assign timeout_err = (state == S_ERR);
  assign fsm_state   = state;

endmodule
